// File: rtl/mult_div_sequencer.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide, one bit per cycle.
// Latency WIDTH+2 edges from start to done (2 edges for divide by zero); start ignored while not idle.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d, rsign_q, rsign_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             signed_op, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, add_a, add_b;
  logic [WIDTH+1:0] sum;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // One shared adder: accumulate for multiply, trial-subtract (a + ~b + 1) for divide.
  always_comb begin
    signed_op = ~op_q[0];
    is_div    = op_q[1];
    a_mag     = (signed_op && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (signed_op && b_q[WIDTH-1]) ? -b_q : b_q;
    shifted   = {acc_q, mq_q[WIDTH-1]};
    add_a     = is_div ? shifted : {1'b0, acc_q};
    if (is_div)
      add_b = ~{1'b0, mcand_q};
    else
      add_b = mq_q[0] ? {1'b0, mcand_q} : '0;
    sum       = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, is_div};
    prod      = {acc_q, mq_q};
    prod_neg  = -prod;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    rsign_d = rsign_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d  = signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rsign_d = signed_op & a_q[WIDTH-1];
        acc_d   = '0;
        cnt_d   = '0;
        mcand_d = is_div ? b_mag : a_mag;
        mq_d    = is_div ? a_mag : b_mag;
        // Zero divisor skips the iterations but still commits through FIX.
        if (is_div && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          if (sum[WIDTH+1]) begin
            acc_d = sum[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[WIDTH:1];
          mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div) begin
          lo_d = sign_q  ? -mq_q  : mq_q;
          hi_d = rsign_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = sign_q ? prod_neg : prod;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done_o     = (state_q == S_DONE);
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
